// File: rtl/darksocv_pkg.sv
// rtl/darksocv_pkg.sv - shared constants and state types for the darksocv SoC shell
package darksocv_pkg;

  localparam logic [31:0] IOBASE = 32'h8000_0000;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // IO word offsets, addr[3:2]
  localparam logic [1:0] IO_UART_STAT = 2'd0;
  localparam logic [1:0] IO_UART_DATA = 2'd1;
  localparam logic [1:0] IO_LED       = 2'd2;
  localparam logic [1:0] IO_TIMER     = 2'd3;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  typedef enum logic {C_FETCH, C_EXEC} core_state_t;

endpackage

// File: rtl/darkriscv.sv
// rtl/darkriscv.sv - minimal multi-cycle RV32 core (LUI, OP-IMM add, LW, SB/SH/SW)
// Ports: clk, res (active-high async), hlt (stall); ireq/iaddr/idata fetch side;
//        drd/dwr/daddr/dwdata/dbe/drdata data side. Requests are held while hlt=1.
module darkriscv
  import darksocv_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              hlt,
  output logic              ireq,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              drd,
  output logic              dwr,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  output logic [BE_W-1:0]   dbe,
  input  logic [DATA_W-1:0] drdata
);

  core_state_t state, state_nx;
  logic [31:0] pc, ir;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] r1, r2, imm_i, imm_s, imm_u, wb_val;
  logic        is_load, is_store, is_lui, is_opimm, wb_en, step;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_u    = {ir[31:12], 12'b0};
  assign is_load  = opcode == 7'b0000011;
  assign is_store = opcode == 7'b0100011;
  assign is_lui   = opcode == 7'b0110111;
  assign is_opimm = opcode == 7'b0010011;

  // x0 is never written, so it is forced to zero on read instead
  assign r1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign r2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  assign ireq  = state == C_FETCH;
  assign iaddr = pc;
  assign drd   = (state == C_EXEC) && is_load;
  assign dwr   = (state == C_EXEC) && is_store;
  assign daddr = r1 + (is_store ? imm_s : imm_i);
  assign step  = (state == C_EXEC) && !hlt;

  // sub-word stores replicate the data across lanes and select lanes with be
  always_comb begin
    dwdata = r2;
    dbe    = 4'hf;
    if (is_store) begin
      case (ir[14:12])
        3'b000: begin dwdata = {4{r2[7:0]}};  dbe = 4'b0001 << daddr[1:0]; end
        3'b001: begin dwdata = {2{r2[15:0]}}; dbe = 4'b0011 << {daddr[1], 1'b0}; end
        default: begin dwdata = r2; dbe = 4'hf; end
      endcase
    end
  end

  always_comb begin
    wb_en  = is_lui | is_opimm | is_load;
    wb_val = is_lui ? imm_u : is_load ? drdata : r1 + imm_i;
  end

  always_comb begin
    state_nx = state;
    case (state)
      C_FETCH: if (!hlt) state_nx = C_EXEC;
      C_EXEC:  if (!hlt) state_nx = C_FETCH;
      default: state_nx = C_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= C_FETCH;
      pc    <= '0;
      ir    <= 32'h0000_0013;
    end else begin
      state <= state_nx;
      if (state == C_FETCH && !hlt) ir <= idata;
      if (step) pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (step && wb_en && rd != 5'd0) regs[rd] <= wb_val;
  end

endmodule

// File: rtl/darksocv_uart.sv
// rtl/darksocv_uart.sv - 8N1 UART transmitter and receiver, UDIV clocks per bit
// Ports: clk, rst_n; tx_start/tx_data -> txd, tx_busy; rxd -> rx_valid/rx_data, rx_clear.
module darksocv_uart
  import darksocv_pkg::*;
#(
  parameter int UDIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd,
  input  logic       rxd,
  input  logic       rx_clear,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(UDIV + 1);

  uart_state_t     tx_state, tx_state_nx, rx_state, rx_state_nx;
  logic [CW-1:0]   tx_cnt, tx_cnt_nx, rx_cnt, rx_cnt_nx;
  logic [2:0]      tx_bit, tx_bit_nx, rx_bit, rx_bit_nx;
  logic [7:0]      tx_shift, tx_shift_nx, rx_shift, rx_shift_nx;
  logic            tx_tick, rx_tick, rx_half, rx_done;
  logic            rx_meta, rx_sync, rx_prev;

  assign tx_tick = tx_cnt == CW'(UDIV - 1);
  assign rx_tick = rx_cnt == CW'(UDIV - 1);
  assign rx_half = rx_cnt == CW'(UDIV / 2 - 1);
  assign tx_busy = tx_state != U_IDLE;
  assign txd     = (tx_state == U_START) ? 1'b0 :
                   (tx_state == U_DATA)  ? tx_shift[0] : 1'b1;

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_tick ? '0 : tx_cnt + 1'b1;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    case (tx_state)
      U_IDLE: begin
        tx_cnt_nx = '0;
        if (tx_start) begin
          tx_state_nx = U_START;
          tx_shift_nx = tx_data;
        end
      end
      U_START: if (tx_tick) begin
        tx_state_nx = U_DATA;
        tx_bit_nx   = 3'd0;
      end
      U_DATA: if (tx_tick) begin
        tx_shift_nx = {1'b0, tx_shift[7:1]};
        tx_bit_nx   = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_nx = U_STOP;
      end
      U_STOP: if (tx_tick) tx_state_nx = U_IDLE;
      default: tx_state_nx = U_IDLE;
    endcase
  end

  // RX: the start bit is re-checked half a bit after the falling edge, then
  // every following sample lands mid-bit
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + 1'b1;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    case (rx_state)
      U_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev && !rx_sync) rx_state_nx = U_START;
      end
      U_START: if (rx_half) begin
        rx_cnt_nx   = '0;
        rx_bit_nx   = 3'd0;
        rx_state_nx = rx_sync ? U_IDLE : U_DATA;
      end
      U_DATA: if (rx_tick) begin
        rx_cnt_nx   = '0;
        rx_shift_nx = {rx_sync, rx_shift[7:1]};
        rx_bit_nx   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_nx = U_STOP;
      end
      U_STOP: if (rx_tick) begin
        rx_cnt_nx   = '0;
        rx_state_nx = U_IDLE;
        rx_done     = rx_sync;
      end
      default: rx_state_nx = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= U_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      rx_state <= U_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
      rx_meta  <= rxd;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      // a fresh byte wins over a simultaneous read-clear
      if (rx_done) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
      end else if (rx_clear) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/darksocv_soc.sv
// rtl/darksocv_soc.sv - SoC shell: reset sync, I/D arbitration on MEM2, IO decode, LED, timer, UART
// Ports: XCLK, XRES (async active-low), UART_RXD/UART_TXD;
//        MEM2 master: mem2_addr/wdata/be/rd/wr out, mem2_rdata/ready in.
module darksocv_soc
  import darksocv_pkg::*;
#(
  parameter int BOARD_CK  = 100_000_000,
  parameter int UART_BAUD = 115200
) (
  input  logic              XCLK,
  input  logic              XRES,
  input  logic              UART_RXD,
  output logic              UART_TXD,
  output logic [ADDR_W-1:0] mem2_addr,
  output logic [DATA_W-1:0] mem2_wdata,
  output logic [BE_W-1:0]   mem2_be,
  output logic              mem2_rd,
  output logic              mem2_wr,
  input  logic [DATA_W-1:0] mem2_rdata,
  input  logic              mem2_ready
);

  localparam int UDIV = BOARD_CK / UART_BAUD;

  logic [1:0]  rst_ff;
  logic        rst_n;
  logic        ireq, drd, dwr, hlt;
  logic [31:0] iaddr, daddr, dwdata, drdata, io_rdata, timer;
  logic [3:0]  dbe;
  logic        data_req, data_io, data_mem, fetch_mem, mem_req;
  logic        io_wr, io_rd, tx_busy, rx_valid;
  logic [1:0]  io_off;
  logic [7:0]  rx_data;
  logic [15:0] led;

  // assertion is immediate, release takes two XCLK edges
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) rst_ff <= 2'b00;
    else       rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  darkriscv core0 (
    .clk    (XCLK),
    .res    (~rst_n),
    .hlt    (hlt),
    .ireq   (ireq),
    .iaddr  (iaddr),
    .idata  (mem2_rdata),
    .drd    (drd),
    .dwr    (dwr),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dbe    (dbe),
    .drdata (drdata)
  );

  // data access owns MEM2 whenever present; fetch only when no data access
  assign data_req  = drd | dwr;
  assign data_io   = data_req && (daddr[31] == IOBASE[31]);
  assign data_mem  = data_req && !data_io;
  assign fetch_mem = ireq && !data_req;
  assign mem_req   = rst_n && (data_mem || fetch_mem);

  // gating with rst_n makes rd/wr drop as soon as XRES falls
  assign mem2_rd    = rst_n && ((data_mem && drd) || fetch_mem);
  assign mem2_wr    = rst_n && data_mem && dwr;
  assign mem2_addr  = !rst_n ? '0 : data_mem ? daddr : fetch_mem ? iaddr : '0;
  assign mem2_be    = !rst_n ? '0 : data_mem ? dbe : fetch_mem ? 4'hf : '0;
  assign mem2_wdata = mem2_wr ? dwdata : '0;
  assign hlt        = mem_req && !mem2_ready;

  assign io_off = daddr[3:2];
  assign io_wr  = rst_n && data_io && dwr;
  assign io_rd  = rst_n && data_io && drd;
  assign drdata = data_io ? io_rdata : mem2_rdata;

  always_comb begin
    io_rdata = '0;
    case (io_off)
      IO_UART_STAT: io_rdata = {30'd0, rx_valid, tx_busy};
      IO_UART_DATA: io_rdata = {24'd0, rx_data};
      IO_LED:       io_rdata = {16'd0, led};
      IO_TIMER:     io_rdata = timer;
      default:      io_rdata = '0;
    endcase
  end

  always_ff @(posedge XCLK or negedge rst_n) begin
    if (!rst_n) begin
      led   <= '0;
      timer <= '0;
    end else begin
      if (io_wr && io_off == IO_LED) begin
        if (dbe[0]) led[7:0]  <= dwdata[7:0];
        if (dbe[1]) led[15:8] <= dwdata[15:8];
      end
      if (io_wr && io_off == IO_TIMER) timer <= dwdata;
      else                             timer <= timer + 32'd1;
    end
  end

  darksocv_uart #(.UDIV(UDIV)) uart0 (
    .clk      (XCLK),
    .rst_n    (rst_n),
    .tx_start (io_wr && io_off == IO_UART_DATA),
    .tx_data  (dwdata[7:0]),
    .tx_busy  (tx_busy),
    .txd      (UART_TXD),
    .rxd      (UART_RXD),
    .rx_clear (io_rd && io_off == IO_UART_DATA),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

endmodule

// File: tb/tb_darksocv_soc.sv
// tb/tb_darksocv_soc.sv - self-checking bench for darksocv_soc
module tb_darksocv_soc;

  localparam int BOARD_CK  = 1_600_000;
  localparam int UART_BAUD = 100_000;
  localparam int UDIV      = BOARD_CK / UART_BAUD;

  logic        clk = 1'b0;
  logic        XRES = 1'b0;
  logic        UART_RXD = 1'b1;
  logic        UART_TXD;
  logic [31:0] mem2_addr, mem2_wdata, mem2_rdata;
  logic [3:0]  mem2_be;
  logic        mem2_rd, mem2_wr, mem2_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t     exp_tab [9];
  wr_exp_t     sb_q [$];
  logic [31:0] prog [0:63];
  bit          gate [0:63];

  always #5 clk = ~clk;

  darksocv_soc #(.BOARD_CK(BOARD_CK), .UART_BAUD(UART_BAUD)) dut (
    .XCLK       (clk),
    .XRES       (XRES),
    .UART_RXD   (UART_RXD),
    .UART_TXD   (UART_TXD),
    .mem2_addr  (mem2_addr),
    .mem2_wdata (mem2_wdata),
    .mem2_be    (mem2_be),
    .mem2_rd    (mem2_rd),
    .mem2_wr    (mem2_wr),
    .mem2_rdata (mem2_rdata),
    .mem2_ready (mem2_ready)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] i_lui(input int rd, input int imm);
    logic [19:0] u; logic [4:0] r;
    u = imm[19:0]; r = rd[4:0];
    return {u, r, 7'b0110111};
  endfunction

  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i; logic [4:0] r, s;
    i = imm[11:0]; r = rd[4:0]; s = rs1[4:0];
    return {i, s, 3'b000, r, 7'b0010011};
  endfunction

  function automatic logic [31:0] i_lw(input int rd, input int rs1, input int imm);
    logic [11:0] i; logic [4:0] r, s;
    i = imm[11:0]; r = rd[4:0]; s = rs1[4:0];
    return {i, s, 3'b010, r, 7'b0000011};
  endfunction

  function automatic logic [31:0] i_st(input int f3, input int rs2, input int rs1, input int imm);
    logic [11:0] i; logic [4:0] a, s; logic [2:0] f;
    i = imm[11:0]; a = rs2[4:0]; s = rs1[4:0]; f = f3[2:0];
    return {i[11:5], a, s, f, i[4:0], 7'b0100011};
  endfunction

  // memory behind MEM2: zero-wait except for gated fetch addresses
  always @(negedge clk) begin
    wr_exp_t e;
    if (mem2_rd) begin
      if (mem2_addr < 32'h100 && gate[mem2_addr[7:2]]) begin
        mem2_ready = 1'b0;
      end else begin
        mem2_ready = 1'b1;
        mem2_rdata = (mem2_addr < 32'h100) ? prog[mem2_addr[7:2]] : 32'h0;
      end
    end else if (mem2_wr) begin
      mem2_ready = 1'b1;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h", mem2_addr, mem2_wdata);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_addr"}, mem2_addr, e.addr);
        check({e.name, "_data"}, mem2_wdata, e.data);
        check({e.name, "_be"}, {28'd0, mem2_be}, 32'hf);
      end
    end else begin
      mem2_ready = 1'b0;
    end
  end

  task automatic wait_fetch(input logic [31:0] a, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      if (mem2_rd && mem2_addr == a) seen = 1'b1;
    end
    check(nm, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_tx(input logic [7:0] b);
    bit seen;
    int n;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (UART_TXD === 1'b0) seen = 1'b1;
    end
    check("tx_start_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      n = 1;
      while (n < 4 * UDIV) begin
        @(posedge clk); #1;
        if (UART_TXD !== 1'b0) break;
        n++;
      end
      check("tx_start_len", n, UDIV);
      for (int k = 0; k < 9; k++) begin
        repeat ((k == 0) ? UDIV / 2 : UDIV) @(posedge clk);
        #1;
        check($sformatf("tx_bit%0d", k), {31'd0, UART_TXD}, (k < 8) ? {31'd0, b[k]} : 32'd1);
      end
    end
  endtask

  task automatic hold_test();
    bit ok;
    int pending;
    wait_fetch(32'd20, "hold_fetch_seen");
    pending = sb_q.size();
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!(mem2_rd && !mem2_wr && mem2_addr == 32'd20 && mem2_be == 4'hf)) ok = 1'b0;
    end
    check("hold_stable", {31'd0, ok}, 32'd1);
    check("hold_no_progress", sb_q.size(), pending);
    gate[5] = 1'b0;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(negedge clk);
    UART_RXD = 1'b0;
    repeat (UDIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      UART_RXD = b[k];
      repeat (UDIV) @(negedge clk);
    end
    UART_RXD = stop;
    repeat (UDIV) @(negedge clk);
    UART_RXD = 1'b1;
    repeat (2 * UDIV) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem2_ready = 1'b0;
    mem2_rdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      prog[i] = 32'h0000_0013;
      gate[i] = 1'b0;
    end
    prog[0]  = i_lui(1, 32'h80000);
    prog[1]  = i_addi(2, 0, 32'h41);
    prog[2]  = i_st(2, 2, 1, 4);
    prog[3]  = i_lw(3, 1, 0);
    prog[4]  = i_st(2, 3, 0, 32'h100);
    prog[5]  = i_lui(4, 32'hC);
    prog[6]  = i_addi(4, 4, -273);
    prog[7]  = i_st(1, 4, 1, 8);
    prog[8]  = i_lw(5, 1, 8);
    prog[9]  = i_st(2, 5, 0, 32'h104);
    prog[10] = i_addi(6, 0, 32'h12);
    prog[11] = i_st(0, 6, 1, 8);
    prog[12] = i_lw(5, 1, 8);
    prog[13] = i_st(2, 5, 0, 32'h108);
    prog[14] = i_lw(3, 1, 0);
    prog[15] = i_st(2, 3, 0, 32'h10C);
    prog[16] = i_lw(7, 1, 4);
    prog[17] = i_st(2, 7, 0, 32'h110);
    prog[18] = i_lw(3, 1, 0);
    prog[19] = i_st(2, 3, 0, 32'h114);
    prog[20] = i_lw(3, 1, 0);
    prog[21] = i_st(2, 3, 0, 32'h118);
    prog[22] = i_addi(8, 0, 100);
    prog[23] = i_st(2, 8, 1, 12);
    prog[24] = i_lw(9, 1, 12);
    prog[25] = i_st(2, 9, 0, 32'h11C);
    prog[26] = i_addi(8, 0, -1);
    prog[27] = i_st(2, 8, 1, 12);
    prog[28] = i_lw(9, 1, 12);
    prog[29] = i_st(2, 9, 0, 32'h120);
    gate[5]  = 1'b1;
    gate[14] = 1'b1;
    gate[20] = 1'b1;
    gate[30] = 1'b1;

    exp_tab[0] = '{"stat_tx_busy",  32'h100, 32'h0000_0001};
    exp_tab[1] = '{"led_sh_beef",   32'h104, 32'h0000_BEEF};
    exp_tab[2] = '{"led_sb_12",     32'h108, 32'h0000_BE12};
    exp_tab[3] = '{"stat_rx_valid", 32'h10C, 32'h0000_0002};
    exp_tab[4] = '{"rx_data_5a",    32'h110, 32'h0000_005A};
    exp_tab[5] = '{"stat_cleared",  32'h114, 32'h0000_0000};
    exp_tab[6] = '{"stat_bad_stop", 32'h118, 32'h0000_0000};
    exp_tab[7] = '{"timer_load",    32'h11C, 32'd101};
    exp_tab[8] = '{"timer_wrap",    32'h120, 32'h0000_0000};
    for (int i = 0; i < 9; i++) sb_q.push_back(exp_tab[i]);

    #500;
    check("rst_txd",  {31'd0, UART_TXD}, 32'd1);
    check("rst_rd",   {31'd0, mem2_rd},  32'd0);
    check("rst_wr",   {31'd0, mem2_wr},  32'd0);
    check("rst_addr", mem2_addr,         32'd0);
    check("rst_be",   {28'd0, mem2_be},  32'd0);
    #500;
    @(negedge clk);
    XRES = 1'b1;
    @(posedge clk); #1;
    check("rel_edge1_rd", {31'd0, mem2_rd}, 32'd0);
    @(posedge clk); #1;
    check("rel_edge2_rd",   {31'd0, mem2_rd}, 32'd1);
    check("rel_edge2_addr", mem2_addr,        32'd0);

    fork
      check_tx(8'h41);
      hold_test();
    join

    uart_send(8'h5A, 1'b1);
    gate[14] = 1'b0;
    wait_fetch(32'd80, "reach_bad_frame_point");
    uart_send(8'hA5, 1'b0);
    gate[20] = 1'b0;
    wait_fetch(32'd120, "reach_end");
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
